// File: rtl/delay_pipe_pkg.sv
// delay_pipe shared constants and helpers.
// Output combine modes and occupancy sizing.
package delay_pipe_pkg;

  localparam int MODE_PASS = 0;
  localparam int MODE_OR   = 1;
  localparam int MODE_AND  = 2;
  localparam int MODE_XOR  = 3;

  function automatic int occ_width(input int lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/delay_pipe_lane.sv
// One data lane: WIDTH-bit shift register plus
// output combine of the last two stages.
module delay_pipe_lane
  import delay_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int MODE    = MODE_OR
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             adv_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q [LATENCY];
  logic [WIDTH-1:0] data_d [LATENCY];

  always_comb begin
    for (int s = 0; s < LATENCY; s++) begin
      data_d[s] = data_q[s];
    end
    if (adv_i) begin
      data_d[0] = d_i;
      for (int s = 1; s < LATENCY; s++) begin
        data_d[s] = data_q[s-1];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < LATENCY; s++) begin
        data_q[s] <= '0;
      end
    end else begin
      for (int s = 0; s < LATENCY; s++) begin
        data_q[s] <= data_d[s];
      end
    end
  end

  always_comb begin
    case (MODE)
      MODE_OR:  q_o = data_q[LATENCY-1] | data_q[LATENCY-2];
      MODE_AND: q_o = data_q[LATENCY-1] & data_q[LATENCY-2];
      MODE_XOR: q_o = data_q[LATENCY-1] ^ data_q[LATENCY-2];
      default:  q_o = data_q[LATENCY-1];
    endcase
  end

endmodule

// File: rtl/delay_pipe.sv
// Multi-lane delay pipeline with one shared valid chain,
// stall, flush and tap-combine output.
module delay_pipe
  import delay_pipe_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 4,
  parameter int LANES   = 1,
  parameter int MODE    = MODE_OR
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [LANES*WIDTH-1:0]   in_data,
  output logic                     out_valid,
  output logic [LANES*WIDTH-1:0]   out_data,
  output logic [occ_width(LATENCY)-1:0] occupancy
);

  localparam int OW = occ_width(LATENCY);

  logic               adv;
  logic [LATENCY-1:0] vld_q;
  logic [LATENCY-1:0] vld_d;

  // Flush kills valids but freezes data; data only moves on a real advance.
  assign adv = en & ~flush;

  always_comb begin
    vld_d = vld_q;
    if (flush) begin
      vld_d = '0;
    end else if (en) begin
      vld_d = {vld_q[LATENCY-2:0], in_valid};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q <= vld_d;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int s = 0; s < LATENCY; s++) begin
      occupancy = occupancy + OW'(vld_q[s]);
    end
  end

  assign out_valid = (MODE == MODE_PASS) ? vld_q[LATENCY-1]
                   : (vld_q[LATENCY-1] & vld_q[LATENCY-2]);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    delay_pipe_lane #(
      .WIDTH  (WIDTH),
      .LATENCY(LATENCY),
      .MODE   (MODE)
    ) u_lane (
      .clock(clock),
      .reset(reset),
      .adv_i(adv),
      .d_i  (in_data[k*WIDTH +: WIDTH]),
      .q_o  (out_data[k*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_delay_pipe.sv
// Bench for delay_pipe: one instance per combine mode,
// all fed the same stimulus and compared to a stage model.
module tb_delay_pipe;

  localparam int W  = 8;
  localparam int L  = 4;
  localparam int N  = 2;
  localparam int DW = W * N;
  localparam int OW = $clog2(L + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic          en;
  logic          flush;
  logic          in_valid;
  logic [DW-1:0] in_data;

  logic          ov [4];
  logic [DW-1:0] od [4];
  logic [OW-1:0] oc [4];

  int checks   = 0;
  int failures = 0;

  bit            mv [L];
  logic [DW-1:0] md [L];

  always #5 clock = ~clock;

  for (genvar m = 0; m < 4; m++) begin : g_dut
    delay_pipe #(
      .WIDTH(W), .LATENCY(L), .LANES(N), .MODE(m)
    ) u_dut (
      .clock    (clock),
      .reset    (reset),
      .en       (en),
      .flush    (flush),
      .in_valid (in_valid),
      .in_data  (in_data),
      .out_valid(ov[m]),
      .out_data (od[m]),
      .occupancy(oc[m])
    );
  end

  function automatic logic [DW-1:0] exp_data(input int m);
    case (m)
      1:       return md[L-1] | md[L-2];
      2:       return md[L-1] & md[L-2];
      3:       return md[L-1] ^ md[L-2];
      default: return md[L-1];
    endcase
  endfunction

  function automatic logic exp_valid(input int m);
    if (m == 0) return mv[L-1];
    return mv[L-1] & mv[L-2];
  endfunction

  function automatic logic [OW-1:0] exp_occ();
    int c = 0;
    for (int s = 0; s < L; s++) c += int'(mv[s]);
    return OW'(c);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all();
    for (int m = 0; m < 4; m++) begin
      chk($sformatf("m%0d_valid", m), 32'(ov[m]), 32'(exp_valid(m)));
      chk($sformatf("m%0d_data", m), 32'(od[m]), 32'(exp_data(m)));
      chk($sformatf("m%0d_occ", m), 32'(oc[m]), 32'(exp_occ()));
    end
  endtask

  task automatic step(input bit r, input bit f, input bit e,
                      input bit vi, input logic [DW-1:0] d);
    reset = r; flush = f; en = e; in_valid = vi; in_data = d;
    @(posedge clock);
    if (r) begin
      for (int s = 0; s < L; s++) begin mv[s] = 0; md[s] = '0; end
    end else if (f) begin
      for (int s = 0; s < L; s++) mv[s] = 0;
    end else if (e) begin
      for (int s = L - 1; s > 0; s--) begin
        mv[s] = mv[s-1]; md[s] = md[s-1];
      end
      mv[0] = vi; md[0] = d;
    end
    #1;
    check_all();
  endtask

  int vcnt;
  int maxocc;

  initial begin
    for (int s = 0; s < L; s++) begin mv[s] = 0; md[s] = 'x; end
    reset = 1; flush = 0; en = 0; in_valid = 0; in_data = '0;

    step(1, 0, 0, 0, '0);
    step(1, 0, 1, 1, 16'hABCD);
    chk("reset_occ", 32'(oc[0]), 0);
    chk("reset_data", 32'(od[1]), 0);

    // three words through PASS, count valid output cycles
    vcnt = 0;
    step(0, 0, 1, 1, 16'h0101);
    step(0, 0, 1, 1, 16'h0202);
    step(0, 0, 1, 1, 16'h0303);
    step(0, 0, 1, 0, 16'h5A5A);
    chk("pass_first", 32'(od[0]), 32'h0101);
    for (int i = 0; i < 6; i++) begin
      if (ov[0]) vcnt++;
      step(0, 0, 1, 0, 16'(i));
    end
    chk("pass_vcnt", 32'(vcnt), 3);

    // OR / AND / XOR pairs
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 1, 16'h0100);
    step(0, 0, 1, 1, 16'h0002);
    step(0, 0, 1, 0, 16'h0000);
    step(0, 0, 1, 0, 16'h0000);
    chk("or_pair", 32'(od[1]), 32'h0102);
    chk("or_valid", 32'(ov[1]), 1);
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 1, 16'hFF00);
    step(0, 0, 1, 1, 16'h0FF0);
    step(0, 0, 1, 0, 16'h0000);
    step(0, 0, 1, 0, 16'h0000);
    chk("xor_pair", 32'(od[3]), 32'hF0F0);
    chk("and_pair", 32'(od[2]), 32'h0F00);
    step(0, 0, 1, 0, 16'h0000);
    chk("or_valid_once", 32'(ov[1]), 0);

    // stall with full pipe
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 16'($urandom));
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 1'($urandom), 16'($urandom));
      chk("stall_occ", 32'(oc[0]), 4);
    end
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 16'($urandom));

    // flush at occupancy 3
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 16'($urandom));
    chk("pre_flush_occ", 32'(oc[0]), 3);
    step(0, 1, 1, 1, 16'h7777);
    chk("flush_occ", 32'(oc[0]), 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0, 16'($urandom));
      chk("flush_pass_valid", 32'(ov[0]), 0);
    end

    // reset mid-stream
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1, 16'($urandom));
    step(1, 1, 1, 1, 16'hFFFF);
    chk("rst_valid", 32'(ov[0]), 0);
    chk("rst_data", 32'(od[0]), 0);
    chk("rst_occ", 32'(oc[0]), 0);

    // alternating valid
    maxocc = 0;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1, 1'(i % 2 == 0), 16'($urandom));
      if (int'(oc[0]) > maxocc) maxocc = int'(oc[0]);
      if (ov[2]) vcnt++;
    end
    chk("alt_maxocc_le2", 32'(maxocc <= 2), 1);
    chk("alt_and_valid", 32'(vcnt), 0);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(99) < 2), 1'($urandom_range(99) < 6),
           1'($urandom_range(99) < 75), 1'($urandom),
           16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/delay_pipe.md
DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 Parameter WIDTH, default 32, data bits per lane; SHALL be >= 1.
REQ-002 Parameter LATENCY, default 4, number of pipeline stages; SHALL be >= 2.
REQ-003 Parameter LANES, default 1, independent data lanes sharing one valid chain; SHALL be >= 1.
REQ-004 Parameter MODE, default 1, output combine: 0 PASS, 1 OR, 2 AND, 3 XOR; SHALL be fixed at elaboration.
REQ-005 clock  input  1  sole clock; all state SHALL update on its rising edge only.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 en  input  1  advance enable; 0 = hold every stage.
REQ-008 flush  input  1  invalidate all pipeline contents.
REQ-009 in_valid  input  1  qualifies in_data.
REQ-010 in_data  input  LANES*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH].
REQ-011 out_valid  output  1  qualifies out_data.
REQ-012 out_data  output  LANES*WIDTH  combined tap output, same lane packing.
REQ-013 occupancy  output  clog2(LATENCY+1)  count of valid stages.

Function
REQ-014 Stage s (0..LATENCY-1) SHALL hold one valid bit plus LANES*WIDTH data bits.
REQ-015 With en=1, flush=0: stage0 SHALL load {in_valid, in_data}, stage s SHALL load stage s-1 for s>=1.
REQ-016 With en=0, flush=0: all stages SHALL hold value (stall); in_valid/in_data SHALL be ignored.
REQ-017 flush=1 SHALL clear every valid bit at the edge, including the word being presented, regardless of en; data bits SHALL be left unchanged.
REQ-018 PASS mode: out_data SHALL equal stage[LATENCY-1] data; out_valid SHALL equal stage[LATENCY-1] valid.
REQ-019 OR/AND/XOR modes: per lane, out_data SHALL equal stage[LATENCY-1] op stage[LATENCY-2], bitwise; out_valid SHALL equal valid[LATENCY-1] AND valid[LATENCY-2].
REQ-020 out_data and out_valid SHALL be combinational from stage registers only (no input-to-output path).
REQ-021 Latency: a word accepted at edge n with en held high SHALL reach stage[LATENCY-1] after edge n+LATENCY-1; each stalled cycle SHALL add exactly one cycle.
REQ-022 out_data SHALL be driven even when out_valid=0; consumers SHALL ignore it.
REQ-023 occupancy SHALL equal the population count of the registered valid bits, range 0..LATENCY, never wrapping.
REQ-024 Lanes SHALL never interact; a value on lane k SHALL never appear on lane j != k.

Reset
REQ-025 reset=1 at an edge SHALL clear all valid bits and all data bits to 0, overriding en and flush.
REQ-026 After reset: out_valid=0, out_data=0, occupancy=0; reset asserted mid-stream SHALL discard all in-flight words.

Structure
REQ-027 Package delay_pipe_pkg SHALL hold the MODE constants (MODE_PASS=0, MODE_OR=1, MODE_AND=2, MODE_XOR=3) and the occupancy width function.
REQ-028 One sub-module, delay_pipe_lane, SHALL implement a single lane's WIDTH-bit shift register and combine; delay_pipe SHALL instantiate LANES of them plus one shared valid chain and occupancy logic.

Verification (WIDTH=8, LATENCY=4, LANES=2 unless stated)
REQ-029 MODE=PASS, en=1, feed valid words 0x0101,0x0202,0x0303 on consecutive edges -> out_data 0x0101 visible after the 4th edge, then 0x0202, 0x0303, out_valid=1 for exactly 3 cycles.
REQ-030 MODE=OR, feed 0x0100 then 0x0002 -> out_data=0x0102 with out_valid=1 for one cycle once both occupy the last two stages; MODE=XOR with 0xFF00, 0x0FF0 -> 0xF0F0.
REQ-031 Fill 4 valid words, hold en=0 for 5 cycles -> out_data/out_valid/occupancy=4 frozen; en=1 resumes with no word lost or duplicated.
REQ-032 occupancy=3, assert flush with en=1 and in_valid=1 -> next cycle occupancy=0, out_valid=0 for the next 4 cycles.
REQ-033 Reset asserted with occupancy=4 -> next cycle out_valid=0, out_data=0x0000, occupancy=0.
REQ-034 Alternate in_valid 1,0,1,0 -> occupancy toggles never above 2 at LATENCY=4; MODE=AND out_valid stays 0 throughout.
